// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM states and
// the number of bits processed per clock.
package serial_add_sub_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/digit_add2.sv
// Combinational 2-bit carry-lookahead digit: sum bits, the carry into the
// upper bit (needed for overflow on the MSB digit) and the digit carry-out.
module digit_add2
  import serial_add_sub_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_d,
  input  logic [DIGIT_W-1:0] b_d,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               c_mid,
  output logic               cout
);

  logic [DIGIT_W-1:0] g;
  logic [DIGIT_W-1:0] p;
  logic               grp_g;
  logic               grp_p;

  always_comb begin
    g     = a_d & b_d;
    p     = a_d ^ b_d;
    c_mid = g[0] | (p[0] & cin);
    sum   = {p[1] ^ c_mid, p[0] ^ cin};
    // Group terms let the digit carry-out skip the intermediate ripple.
    grp_g = g[1] | (p[1] & g[0]);
    grp_p = p[1] & p[0];
    cout  = grp_g | (grp_p & cin);
  end

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial add/subtract: accepts an operand set, resolves one 2-bit digit
// per clock LSB first, then holds the result until the consumer takes it.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = $clog2(NDIG);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;

  logic [DIGIT_W-1:0] dig_a, dig_b, dig_sum;
  logic               dig_cmid, dig_cout;

  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        dig_a = opa_q[k*DIGIT_W +: DIGIT_W];
        dig_b = opb_q[k*DIGIT_W +: DIGIT_W];
      end
    end
  end

  digit_add2 u_digit (
    .a_d   (dig_a),
    .b_d   (dig_b),
    .cin   (carry_q),
    .sum   (dig_sum),
    .c_mid (dig_cmid),
    .cout  (dig_cout)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          // Subtraction as a + ~b + 1: invert b here, inject the +1 as carry-in.
          opb_d   = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < NDIG; k++) begin
          if (cnt_q == CNT_W'(k)) res_d[k*DIGIT_W +: DIGIT_W] = dig_sum;
        end
        carry_d = dig_cout;
        if (cnt_q == LAST_DIG) begin
          ovf_d   = dig_cmid ^ dig_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: operand registers carry no reset; they are always loaded on
  // acceptance before any digit reads them.
  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = res_q;
  assign cout      = carry_q;
  assign ovf       = ovf_q;

endmodule
